// File: rtl/flash_pkg.sv
// Shared constants, FSM state type and command-byte helper for the SPI NOR write engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flash_pkg;
    localparam logic [7:0] OP_WREN    = 8'h06;
    localparam logic [7:0] OP_PP      = 8'h02;
    localparam logic [7:0] OP_SE      = 8'h20;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam int         PAGE_BYTES = 256;
    localparam int         SR_WIP     = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP, S_CMD, S_DATA, S_POLL, S_DONE
    } state_t;

    // Byte idx of the 4-byte command phase: opcode then 24-bit address, MSB first.
    // Sector erase always addresses the start of its 4 KiB sector.
    function automatic logic [7:0] cmd_byte(input logic op, input logic [23:0] a,
                                            input logic [1:0] idx);
        logic [23:0] ea;
        ea = op ? {a[23:12], 12'h000} : a;
        case (idx)
            2'd0:    return op ? OP_SE : OP_PP;
            2'd1:    return ea[23:16];
            2'd2:    return ea[15:8];
            default: return ea[7:0];
        endcase
    endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte shifter: shifts i_tx_byte out on o_si MSB first, captures i_so into o_rx_byte.
// Latency: 16*HALF_PERIOD clk from i_go to the o_byte_done pulse.
// Backpressure: none; i_go is ignored while a byte is in flight.
// Ports: clk/rst, i_go + i_tx_byte (start), i_so (MISO), o_sclk/o_si (bus), o_byte_done, o_rx_byte.
module spi_byte_shifter #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go,
    input  logic [7:0] i_tx_byte,
    input  logic       i_so,
    output logic       o_sclk,
    output logic       o_si,
    output logic       o_byte_done,
    output logic [7:0] o_rx_byte
);
    localparam int            CW      = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

    logic          r_active;
    logic          r_sclk;
    logic          r_si;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic [7:0]    r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_si     <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_sh     <= 8'h00;
            r_rx     <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (i_go && !r_active) begin
                // First bit is presented a full low half-period before the first rising edge.
                r_active <= 1'b1;
                r_sh     <= i_tx_byte;
                r_si     <= i_tx_byte[7];
                r_cnt    <= '0;
                r_bit    <= 3'd0;
                r_sclk   <= 1'b0;
            end else if (r_active) begin
                if (r_cnt == HP_LAST) begin
                    r_cnt <= '0;
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[6:0], i_so};
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_sh  <= {r_sh[6:0], 1'b0};
                            r_si  <= r_sh[6];
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_sclk      = r_sclk;
    assign o_si        = r_si;
    assign o_byte_done = r_done;
    assign o_rx_byte   = r_rx;
endmodule

// File: rtl/flash_writer.sv
// Single-bit SPI NOR program/erase engine: WREN, PP/SE, RDSR poll, page split at 256-byte boundaries.
// Latency: ~16*HALF_PERIOD clk per bus byte plus CS_GAP between commands; done pulses after WIP clears.
// Backpressure: in_ready high only at DATA byte boundaries; cs/sclk hold low while in_valid is low.
// Ports: clk/rst, addr/op/start (command), in_data/in_valid/in_last/in_ready (byte stream),
//        busy/done (status), cs/sclk/si/so/wp/hold (flash pins).
module flash_writer
    import flash_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int CS_GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] addr,
    input  logic        op,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        cs,
    output logic        sclk,
    inout  wire         si,
    inout  wire         so,
    inout  wire         wp,
    inout  wire         hold
);
    localparam int            GW        = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
    localparam logic [7:0]    PAGE_LAST = 8'(PAGE_BYTES - 1);

    state_t        r_state;
    state_t        r_gap_next;
    logic [GW-1:0] r_gap_cnt;
    logic [23:0]   r_addr;
    logic          r_op;
    logic          r_cs;
    logic          r_busy;
    logic          r_done;
    logic          r_in_ready;
    logic          r_go;
    logic [7:0]    r_tx;
    logic          r_shifting;
    logic [1:0]    r_idx;
    logic          r_last;
    logic          r_page_end;

    logic          w_byte_done;
    logic [7:0]    w_rx;
    logic          w_si;

    spi_byte_shifter #(.HALF_PERIOD(HALF_PERIOD)) u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_go        (r_go),
        .i_tx_byte   (r_tx),
        .i_so        (so),
        .o_sclk      (sclk),
        .o_si        (w_si),
        .o_byte_done (w_byte_done),
        .o_rx_byte   (w_rx)
    );

    // r_shifting marks a byte handed to the shifter; when clear, the state issues its next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gap_next <= S_IDLE;
            r_gap_cnt  <= '0;
            r_addr     <= 24'h000000;
            r_op       <= 1'b0;
            r_cs       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
            r_go       <= 1'b0;
            r_tx       <= 8'h00;
            r_shifting <= 1'b0;
            r_idx      <= 2'd0;
            r_last     <= 1'b0;
            r_page_end <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        r_addr     <= addr;
                        r_op       <= op;
                        r_busy     <= 1'b1;
                        r_page_end <= 1'b0;
                        r_idx      <= 2'd0;
                        r_state    <= S_WREN;
                    end
                end
                S_WREN: begin
                    if (!r_shifting) begin
                        r_cs       <= 1'b0;
                        r_tx       <= OP_WREN;
                        r_go       <= 1'b1;
                        r_shifting <= 1'b1;
                    end else if (w_byte_done) begin
                        r_shifting <= 1'b0;
                        r_cs       <= 1'b1;
                        r_gap_cnt  <= '0;
                        r_gap_next <= S_CMD;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= r_gap_next;
                        if (r_gap_next == S_DONE) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_CMD: begin
                    if (!r_shifting) begin
                        r_cs       <= 1'b0;
                        r_tx       <= cmd_byte(r_op, r_addr, r_idx);
                        r_go       <= 1'b1;
                        r_shifting <= 1'b1;
                    end else if (w_byte_done) begin
                        r_shifting <= 1'b0;
                        if (r_idx == 2'd3) begin
                            r_idx <= 2'd0;
                            if (r_op) begin
                                r_cs       <= 1'b1;
                                r_gap_cnt  <= '0;
                                r_gap_next <= S_POLL;
                                r_state    <= S_GAP;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= S_DATA;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (!r_shifting) begin
                        if (in_valid && r_in_ready) begin
                            r_in_ready <= 1'b0;
                            r_tx       <= in_data;
                            r_last     <= in_last;
                            r_go       <= 1'b1;
                            r_shifting <= 1'b1;
                        end
                    end else if (w_byte_done) begin
                        r_shifting <= 1'b0;
                        r_addr     <= r_addr + 24'd1;
                        // The final byte wins over a page boundary: it finishes the operation.
                        if (r_last || r_addr[7:0] == PAGE_LAST) begin
                            r_page_end <= !r_last;
                            r_cs       <= 1'b1;
                            r_gap_cnt  <= '0;
                            r_gap_next <= S_POLL;
                            r_state    <= S_GAP;
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_POLL: begin
                    // RDSR once, then dummy bytes keep cs low while status bytes stream back.
                    if (!r_shifting) begin
                        r_cs       <= 1'b0;
                        r_tx       <= (r_idx == 2'd0) ? OP_RDSR : 8'h00;
                        r_go       <= 1'b1;
                        r_shifting <= 1'b1;
                    end else if (w_byte_done) begin
                        r_shifting <= 1'b0;
                        if (r_idx == 2'd0) begin
                            r_idx <= 2'd1;
                        end else if (!w_rx[SR_WIP]) begin
                            r_idx      <= 2'd0;
                            r_cs       <= 1'b1;
                            r_gap_cnt  <= '0;
                            r_gap_next <= r_page_end ? S_WREN : S_DONE;
                            r_state    <= S_GAP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign cs       = r_cs;
    assign si       = w_si;
    assign wp       = 1'b1;
    assign hold     = 1'b1;
endmodule
